// File: rtl/regfile_trace_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_trace_monitor
// Purpose  : Shadows the MIPS core's register-file write port, logs every
//            value-changing write (with cycle stamp) into a show-ahead trace
//            FIFO, and bounds capture to a programmable cycle window.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_trace_monitor #(
   parameter int DATA_W  = 32,
   parameter int NREGS   = 32,
   parameter int ADDR_W  = 5,
   parameter int DEPTH   = 16,
   parameter int CYCLE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CYCLE_W-1:0] run_cycles,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data,
   output logic               tr_valid,
   input  logic               tr_ready,
   output logic [ADDR_W-1:0]  tr_addr,
   output logic [DATA_W-1:0]  tr_data,
   output logic [CYCLE_W-1:0] tr_cycle,
   output logic               overflow,
   output logic               running,
   output logic               done,
   output logic [CYCLE_W-1:0] cycle_count
);

   localparam int               c_ptr_w   = $clog2(DEPTH);
   localparam logic [c_ptr_w:0] c_ptr_one = 1;
   localparam logic [CYCLE_W-1:0] c_cyc_one = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CYCLE_W-1:0]   limit_q, limit_d;
   logic [CYCLE_W-1:0]   cycle_q, cycle_d;
   logic                 overflow_q, overflow_d;
   logic                 running_q, running_d;
   logic                 done_q, done_d;
   // Pointers carry one extra bit so full and empty are distinguishable.
   logic [c_ptr_w:0]     wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w:0]     rd_ptr_q, rd_ptr_d;

   logic [DATA_W-1:0]    shadow_q [NREGS];
   logic [ADDR_W-1:0]    fifo_addr_q [DEPTH];
   logic [DATA_W-1:0]    fifo_data_q [DEPTH];
   logic [CYCLE_W-1:0]   fifo_cyc_q  [DEPTH];

   logic w_in_run;
   logic w_addr_ok;
   logic w_dbg_ok;
   logic w_shadow_we;
   logic w_log;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;
   logic w_start;

   // Write qualification, FIFO status and handshake decode.
   always_comb begin
      w_in_run    = (state_q == S_RUN);
      w_addr_ok   = (wr_addr != '0) && (32'(wr_addr) < NREGS);
      w_dbg_ok    = (32'(dbg_addr) < NREGS);
      // Shadow follows every qualifying write in RUN, even when the entry is dropped.
      w_shadow_we = w_in_run && wr_en && w_addr_ok;
      w_log       = w_shadow_we && (wr_data != shadow_q[wr_addr]);
      w_empty     = (wr_ptr_q == rd_ptr_q);
      w_full      = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                    (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
      w_pop       = !w_empty && tr_ready;
      // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
      w_push      = w_log && (!w_full || w_pop);
      w_drop      = w_log && w_full && !w_pop;
      w_start     = start && (state_q != S_RUN);
   end

   // Next-state logic for the window FSM, cycle counter and FIFO pointers.
   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      cycle_d    = cycle_q;
      overflow_d = overflow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            cycle_d = cycle_q + c_cyc_one;
            // A zero limit means the window never closes; the counter just wraps.
            if ((limit_q != '0) && (cycle_q == limit_q - c_cyc_one)) state_d = S_DONE;
         end
         S_DONE: begin
            if (start) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase

      if (w_start) begin
         // New window: fresh counter, fresh trace, shadow kept intact.
         limit_d    = run_cycles;
         cycle_d    = '0;
         overflow_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (w_pop)  rd_ptr_d   = rd_ptr_q + c_ptr_one;
         if (w_push) wr_ptr_d   = wr_ptr_q + c_ptr_one;
         if (w_drop) overflow_d = 1'b1;
      end

      running_d = (state_d == S_RUN);
      done_d    = (state_d == S_DONE);
   end

   // Control state with registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         limit_q    <= '0;
         cycle_q    <= '0;
         overflow_q <= 1'b0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         cycle_q    <= cycle_d;
         overflow_q <= overflow_d;
         running_q  <= running_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Shadow register file; entry 0 is never written so it always reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
      end else if (w_shadow_we) begin
         shadow_q[wr_addr] <= wr_data;
      end
   end

   // Trace storage; validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_addr_q[wr_ptr_q[c_ptr_w-1:0]] <= wr_addr;
         fifo_data_q[wr_ptr_q[c_ptr_w-1:0]] <= wr_data;
         fifo_cyc_q[wr_ptr_q[c_ptr_w-1:0]]  <= cycle_q;
      end
   end

   assign dbg_data    = w_dbg_ok ? shadow_q[dbg_addr] : '0;
   assign tr_valid    = !w_empty;
   assign tr_addr     = fifo_addr_q[rd_ptr_q[c_ptr_w-1:0]];
   assign tr_data     = fifo_data_q[rd_ptr_q[c_ptr_w-1:0]];
   assign tr_cycle    = fifo_cyc_q[rd_ptr_q[c_ptr_w-1:0]];
   assign overflow    = overflow_q;
   assign running     = running_q;
   assign done        = done_q;
   assign cycle_count = cycle_q;

endmodule
`default_nettype wire
